// File: rtl/branch_predictor_bht_pkg.sv
// -----------------------------------------------------------------------------
// branch_predictor_bht_pkg
//   Shared types and constants for the branch history table and any later
//   predictor (tournament / gshare) that reuses the 2-bit counter.
//
//   bht_cnt_t     : 2-bit saturating counter (SNT, WNT, WT, ST)
//   bht_state_t   : table controller state (INIT sweep, RUN)
//   BHT_CNT_INIT  : value every counter is swept to after reset (WNT)
//   bht_cnt_taken : predicted direction of a counter (its MSB)
// -----------------------------------------------------------------------------
package branch_predictor_bht_pkg;

   typedef enum logic [1:0] {
      BHT_SNT = 2'b00,
      BHT_WNT = 2'b01,
      BHT_WT  = 2'b10,
      BHT_ST  = 2'b11
   } bht_cnt_t;

   typedef enum logic {
      BHT_INIT = 1'b0,
      BHT_RUN  = 1'b1
   } bht_state_t;

   localparam bht_cnt_t BHT_CNT_INIT = BHT_WNT;

   function automatic logic bht_cnt_taken(input bht_cnt_t i_cnt);
      return i_cnt[1];
   endfunction

endpackage

// File: rtl/sat_counter2.sv
// -----------------------------------------------------------------------------
// sat_counter2
//   Combinational next-state of a 2-bit saturating branch counter.
//   Taken moves one step towards ST, not-taken one step towards SNT;
//   the end states saturate.
//
//   Ports:
//     i_cnt   : current counter value
//     i_taken : resolved branch direction (1 = taken)
//     o_cnt   : next counter value
// -----------------------------------------------------------------------------
module sat_counter2
   import branch_predictor_bht_pkg::*;
(
   input  bht_cnt_t i_cnt,
   input  logic     i_taken,
   output bht_cnt_t o_cnt
);

   always_comb begin
      o_cnt = i_cnt;
      if (i_taken) begin
         case (i_cnt)
            BHT_SNT: o_cnt = BHT_WNT;
            BHT_WNT: o_cnt = BHT_WT;
            BHT_WT:  o_cnt = BHT_ST;
            default: o_cnt = BHT_ST;
         endcase
      end else begin
         case (i_cnt)
            BHT_ST:  o_cnt = BHT_WT;
            BHT_WT:  o_cnt = BHT_WNT;
            BHT_WNT: o_cnt = BHT_SNT;
            default: o_cnt = BHT_SNT;
         endcase
      end
   end

endmodule

// File: rtl/branch_predictor_bht.sv
// -----------------------------------------------------------------------------
// branch_predictor_bht
//   Branch history table of ENTRIES 2-bit saturating counters indexed by
//   pc[IDX_BITS+1:2].
//
//   After reset the controller sweeps every counter to WNT, one entry per
//   cycle (ENTRIES cycles), then enters RUN.
//
//   Fetch side (pred_*): a request is accepted when pred_valid && pred_ready.
//   The response (pred_resp_valid, pred_taken) appears the following cycle
//   and reflects the counter as it was in the request cycle. Without a
//   request pred_resp_valid is 0 and pred_taken keeps its last value.
//
//   Execute side (upd_*): an update is accepted in RUN when upd_valid and no
//   redirect is pending. It trains the indexed counter; if the outcome
//   differs from the prediction carried with the branch, a redirect is raised
//   the next cycle.
//
//   Redirect handshake: redirect_valid/redirect_pc are a valid/ready source.
//   Once raised they hold stable until a cycle with redirect_valid &&
//   redirect_ready, and drop the cycle after. Updates arriving while a
//   redirect is pending are wrong-path and are dropped entirely.
//
//   Ports:
//     clk, rst          : clock, asynchronous active-high reset
//     pred_valid/pc     : fetch prediction request
//     pred_ready        : 0 during the init sweep
//     pred_resp_valid   : response strobe, one cycle after acceptance
//     pred_taken        : predicted direction
//     upd_valid/pc      : resolved conditional branch
//     upd_br_en         : actual outcome from the comparator
//     upd_pred_taken    : prediction the branch was fetched with
//     upd_target        : computed taken target
//     redirect_valid/pc : pending misprediction redirect and correct next PC
//     redirect_ready    : fetch accepts the redirect
//     dbg_state         : controller state, for observation only
//     perf_branches     : accepted updates      (BHT_PERF_CNT_EN only)
//     perf_mispredicts  : accepted mispredicts  (BHT_PERF_CNT_EN only)
//
//   Build option: define BHT_PERF_CNT_EN to add the two 32-bit wrapping
//   performance counters and their output ports.
// -----------------------------------------------------------------------------
module branch_predictor_bht
   import branch_predictor_bht_pkg::*;
#(
   parameter int ENTRIES  = 64,
   parameter int IDX_BITS = $clog2(ENTRIES)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pred_valid,
   input  logic [31:0] pred_pc,
   output logic        pred_ready,
   output logic        pred_resp_valid,
   output logic        pred_taken,
   input  logic        upd_valid,
   input  logic [31:0] upd_pc,
   input  logic        upd_br_en,
   input  logic        upd_pred_taken,
   input  logic [31:0] upd_target,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   input  logic        redirect_ready,
`ifdef BHT_PERF_CNT_EN
   output logic [31:0] perf_branches,
   output logic [31:0] perf_mispredicts,
`endif
   output bht_state_t  dbg_state
);

   localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(ENTRIES - 1);

   bht_state_t          r_state;
   logic [IDX_BITS-1:0] r_init_ptr;
   bht_cnt_t            r_cnt [ENTRIES];
   logic                r_resp_valid;
   logic                r_pred_taken;
   logic                r_redirect_valid;
   logic [31:0]         r_redirect_pc;

   logic [IDX_BITS-1:0] w_pred_idx;
   logic [IDX_BITS-1:0] w_upd_idx;
   logic                w_run;
   logic                w_pred_acc;
   logic                w_upd_acc;
   logic                w_mispred;
   bht_cnt_t            w_upd_cur;
   bht_cnt_t            w_upd_nxt;
   logic [31:0]         w_redirect_pc;

   // Only the index bits of the fetch PC matter; higher bits alias.
   logic                w_unused;
   assign w_unused = &{1'b0, pred_pc[31:IDX_BITS+2], pred_pc[1:0]};

   assign w_pred_idx = pred_pc[IDX_BITS+1:2];
   assign w_upd_idx  = upd_pc[IDX_BITS+1:2];
   assign w_run      = (r_state == BHT_RUN);
   assign w_pred_acc = pred_valid && w_run;
   // Wrong-path updates behind a pending redirect are dropped.
   assign w_upd_acc  = upd_valid && w_run && !r_redirect_valid;
   assign w_mispred  = w_upd_acc && (upd_br_en != upd_pred_taken);
   assign w_upd_cur  = r_cnt[w_upd_idx];
   assign w_redirect_pc = upd_br_en ? upd_target : (upd_pc + 32'd4);

   sat_counter2 u_sat (
      .i_cnt   (w_upd_cur),
      .i_taken (upd_br_en),
      .o_cnt   (w_upd_nxt)
   );

   // Controller: INIT sweeps every entry once, then RUN until reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= BHT_INIT;
         r_init_ptr <= '0;
      end else begin
         case (r_state)
            BHT_INIT: begin
               r_init_ptr <= r_init_ptr + 1'b1;
               if (r_init_ptr == LAST_IDX) begin
                  r_state <= BHT_RUN;
               end
            end
            default: begin
               r_state <= BHT_RUN;
            end
         endcase
      end
   end

   // Counter storage has no reset; the INIT sweep gives it a known value.
   // Non-blocking writes make a same-cycle read see the old counter.
   always_ff @(posedge clk) begin
      if (r_state == BHT_INIT) begin
         r_cnt[r_init_ptr] <= BHT_CNT_INIT;
      end else if (w_upd_acc) begin
         r_cnt[w_upd_idx] <= w_upd_nxt;
      end
   end

   // Registered prediction read.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_resp_valid <= 1'b0;
         r_pred_taken <= 1'b0;
      end else begin
         r_resp_valid <= w_pred_acc;
         if (w_pred_acc) begin
            r_pred_taken <= bht_cnt_taken(r_cnt[w_pred_idx]);
         end
      end
   end

   // Redirect source: set on an accepted mispredict, held until accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_redirect_valid <= 1'b0;
         r_redirect_pc    <= '0;
      end else if (r_redirect_valid) begin
         if (redirect_ready) begin
            r_redirect_valid <= 1'b0;
         end
      end else if (w_mispred) begin
         r_redirect_valid <= 1'b1;
         r_redirect_pc    <= w_redirect_pc;
      end
   end

`ifdef BHT_PERF_CNT_EN
   logic [31:0] r_perf_branches;
   logic [31:0] r_perf_mispredicts;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_perf_branches    <= '0;
         r_perf_mispredicts <= '0;
      end else begin
         if (w_upd_acc) begin
            r_perf_branches <= r_perf_branches + 32'd1;
         end
         if (w_mispred) begin
            r_perf_mispredicts <= r_perf_mispredicts + 32'd1;
         end
      end
   end

   assign perf_branches    = r_perf_branches;
   assign perf_mispredicts = r_perf_mispredicts;
`endif

   assign pred_ready      = w_run;
   assign pred_resp_valid = r_resp_valid;
   assign pred_taken      = r_pred_taken;
   assign redirect_valid  = r_redirect_valid;
   assign redirect_pc     = r_redirect_pc;
   assign dbg_state       = r_state;

endmodule

// File: tb/tb_branch_predictor_bht.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor_bht
//   Directed and random stimulus for branch_predictor_bht, checked against a
//   behavioural model: an integer array of counter values 0..3, a cycle count
//   since reset for the init sweep, and a pending-redirect flag/PC.
// -----------------------------------------------------------------------------
module tb_branch_predictor_bht;
  import branch_predictor_bht_pkg::*;

  localparam int ENTRIES = 64;

  logic        clk;
  logic        rst;
  logic        pred_valid;
  logic [31:0] pred_pc;
  logic        pred_ready;
  logic        pred_resp_valid;
  logic        pred_taken;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_br_en;
  logic        upd_pred_taken;
  logic [31:0] upd_target;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;
  bht_state_t  dbg_state;
`ifdef BHT_PERF_CNT_EN
  logic [31:0] perf_branches;
  logic [31:0] perf_mispredicts;
`endif

  branch_predictor_bht #(.ENTRIES(ENTRIES)) dut (
    .clk             (clk),
    .rst             (rst),
    .pred_valid      (pred_valid),
    .pred_pc         (pred_pc),
    .pred_ready      (pred_ready),
    .pred_resp_valid (pred_resp_valid),
    .pred_taken      (pred_taken),
    .upd_valid       (upd_valid),
    .upd_pc          (upd_pc),
    .upd_br_en       (upd_br_en),
    .upd_pred_taken  (upd_pred_taken),
    .upd_target      (upd_target),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .redirect_ready  (redirect_ready),
`ifdef BHT_PERF_CNT_EN
    .perf_branches   (perf_branches),
    .perf_mispredicts(perf_mispredicts),
`endif
    .dbg_state       (dbg_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model
  int          m_cnt [ENTRIES];
  int          m_cycles;
  logic        m_ptaken;
  logic        m_rv;
  logic [31:0] m_rpc;
  logic [31:0] m_br;
  logic [31:0] m_mis;

  int n_total;
  int n_pass;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) m_cnt[i] = 1;
    m_cycles = 0;
    m_ptaken = 1'b0;
    m_rv     = 1'b0;
    m_rpc    = 32'h0;
    m_br     = 32'h0;
    m_mis    = 32'h0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, {31'h0, pred_ready}, 32'h0);
    check({tag, "_resp"},  {31'h0, pred_resp_valid}, 32'h0);
    check({tag, "_taken"}, {31'h0, pred_taken}, 32'h0);
    check({tag, "_rv"},    {31'h0, redirect_valid}, 32'h0);
    check({tag, "_rpc"},   redirect_pc, 32'h0);
    check({tag, "_state"}, {31'h0, dbg_state}, 32'h0);
`ifdef BHT_PERF_CNT_EN
    check({tag, "_pbr"},   perf_branches, 32'h0);
    check({tag, "_pmis"},  perf_mispredicts, 32'h0);
`endif
  endtask

  // Assert reset asynchronously, check outputs before any clock edge,
  // release one time unit after a rising edge.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #2;
    check_reset_outputs(tag);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // One clock cycle: drive inputs, advance model, check all outputs.
  task automatic step(input logic pv, input logic [31:0] ppc,
                      input logic uv, input logic [31:0] upc, input logic ben,
                      input logic ptk, input logic [31:0] tgt, input logic rr);
    logic run;
    logic acc;
    logic exp_resp;
    int   ui;
    pred_valid     = pv;
    pred_pc        = ppc;
    upd_valid      = uv;
    upd_pc         = upc;
    upd_br_en      = ben;
    upd_pred_taken = ptk;
    upd_target     = tgt;
    redirect_ready = rr;

    run      = (m_cycles >= ENTRIES);
    acc      = run && uv && !m_rv;
    exp_resp = run && pv;
    if (exp_resp) m_ptaken = (m_cnt[idx_of(ppc)] >= 2);
    if (acc) begin
      ui = idx_of(upc);
      m_cnt[ui] = ben ? ((m_cnt[ui] < 3) ? m_cnt[ui] + 1 : 3)
                      : ((m_cnt[ui] > 0) ? m_cnt[ui] - 1 : 0);
      m_br = m_br + 32'd1;
    end
    if (m_rv) begin
      if (rr) m_rv = 1'b0;
    end else if (acc && (ben != ptk)) begin
      m_rv  = 1'b1;
      m_rpc = ben ? tgt : upc + 32'd4;
      m_mis = m_mis + 32'd1;
    end
    m_cycles++;

    @(posedge clk);
    #1;
    check("ready", {31'h0, pred_ready}, {31'h0, (m_cycles >= ENTRIES)});
    check("resp_valid", {31'h0, pred_resp_valid}, {31'h0, exp_resp});
    check("pred_taken", {31'h0, pred_taken}, {31'h0, m_ptaken});
    check("redirect_valid", {31'h0, redirect_valid}, {31'h0, m_rv});
    if (m_rv) check("redirect_pc", redirect_pc, m_rpc);
`ifdef BHT_PERF_CNT_EN
    check("perf_branches", perf_branches, m_br);
    check("perf_mispredicts", perf_mispredicts, m_mis);
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic read(input logic [31:0] pc);
    step(1'b1, pc, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic upd(input logic [31:0] pc, input logic ben, input logic ptk,
                     input logic [31:0] tgt, input logic rr);
    step(1'b0, 32'h0, 1'b1, pc, ben, ptk, tgt, rr);
  endtask

  initial begin
    logic [31:0] mis_before;
    n_total        = 0;
    n_pass         = 0;
    rst            = 1'b1;
    pred_valid     = 1'b0;
    pred_pc        = 32'h0;
    upd_valid      = 1'b0;
    upd_pc         = 32'h0;
    upd_br_en      = 1'b0;
    upd_pred_taken = 1'b0;
    upd_target     = 32'h0;
    redirect_ready = 1'b0;
    model_reset();
    #1;
    do_reset("por");

    // Init sweep: requests and updates offered throughout must be ignored.
    for (int i = 0; i < ENTRIES; i++)
      step(1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 1'b0, 32'h200, 1'b0);

    // Fresh counter reads WNT.
    read(32'h100);

    // Taken mispredict at 0x100 -> redirect to 0x200, held without ack.
    upd(32'h100, 1'b1, 1'b0, 32'h200, 1'b0);
    idle(2);
    // Wrong-path update while pending.
    upd(32'h40, 1'b1, 1'b0, 32'h999, 1'b0);
    // Ack, then an update in the cycle the redirect drops.
    upd(32'h40, 1'b0, 1'b1, 32'h0, 1'b1);
    upd(32'h100, 1'b1, 1'b1, 32'h200, 1'b0);
    read(32'h100);
    read(32'h40);

    // Saturate 0x80 down, then one taken -> WNT and redirect.
    for (int i = 0; i < 5; i++) upd(32'h80, 1'b0, 1'b0, 32'h0, 1'b0);
    read(32'h80);
    upd(32'h80, 1'b1, 1'b0, 32'h1234, 1'b0);
    step(1'b1, 32'h80, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    read(32'h80);

    // Same-cycle read and update at 0x300.
    step(1'b1, 32'h300, 1'b1, 32'h300, 1'b1, 1'b1, 32'h500, 1'b0);
    read(32'h300);

    // Not-taken mispredict at the top of the address space wraps to 0.
    mis_before = m_mis;
    upd(32'hFFFF_FFFC, 1'b0, 1'b1, 32'h10, 1'b0);
    check("mispredict_step", m_mis - mis_before, 32'h1);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);

    // Index aliasing: 0x1100 shares the entry of 0x100 (ST).
    read(32'h1100);

    // Random traffic over a few aliasing addresses.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] rpc;
      logic [31:0] wpc;
      rpc = (32'($urandom_range(0, 7)) << 2) | (32'($urandom_range(0, 3)) << 8) | ($urandom & 32'hFFFF_F000);
      wpc = (32'($urandom_range(0, 7)) << 2) | (32'($urandom_range(0, 3)) << 8) | ($urandom & 32'hFFFF_F000);
      step(1'($urandom_range(0, 1)), rpc,
           1'($urandom_range(0, 1)), wpc, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom & 32'hFFFF_FFFC, ($urandom_range(0, 3) == 0));
    end

    // Reset with a redirect pending restarts the sweep.
    if (m_rv) step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    upd(32'h20, 1'b1, 1'b0, 32'h4000, 1'b0);
    do_reset("midrst");
    idle(ENTRIES);
    read(32'h100);
    read(32'h20);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
